// File: rtl/trivium_stream_decryptor.sv
// Byte-serial Trivium consumer: reloads the keystream generator, discards warm-up bits,
// packs eight key bits LSB-first and XORs them with each incoming byte.
module trivium_stream_decryptor #(
   parameter int unsigned WARMUP = 1152
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        ks_load,
   output logic        ks_enable,
   input  logic        ks_bit,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        busy,
   output logic [15:0] bytes_done
);

   localparam int unsigned WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WARM,
      FILL,
      HAVE
   } state_t;

   state_t        state_q, state_d;
   logic [WW-1:0] warm_q, warm_d;
   logic [3:0]    fill_q, fill_d;
   logic [7:0]    key_q, key_d;
   logic          out_valid_d;
   logic [7:0]    out_data_d;
   logic [15:0]   bytes_d;
   logic          accept;

   always_comb begin
      state_d   = state_q;
      warm_d    = warm_q;
      fill_d    = fill_q;
      key_d     = key_q;
      ks_load   = 1'b0;
      ks_enable = 1'b0;
      in_ready  = 1'b0;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = LOAD;
         end
         LOAD: begin
            ks_load = 1'b1;
            key_d   = '0;
            fill_d  = '0;
            warm_d  = '0;
            state_d = (WARMUP == 0) ? FILL : WARM;
         end
         WARM: begin
            ks_enable = 1'b1;
            warm_d    = warm_q + 1'b1;
            if (warm_q == WW'(WARMUP - 1)) state_d = FILL;
         end
         FILL: begin
            // ks_bit lags its enable by one cycle, so slot k captures bit k-1
            ks_enable = (fill_q != 4'd8);
            fill_d    = fill_q + 4'd1;
            if (fill_q != 4'd0) key_d[3'(fill_q - 4'd1)] = ks_bit;
            if (fill_q == 4'd8) begin
               fill_d  = '0;
               state_d = HAVE;
            end
         end
         HAVE: begin
            in_ready = !start && (!out_valid || out_ready);
            accept   = in_ready && in_valid;
            if (accept) begin
               fill_d  = '0;
               state_d = FILL;
            end
         end
         default: state_d = IDLE;
      endcase
      if (start) state_d = LOAD;
   end

   always_comb begin
      out_valid_d = out_valid;
      out_data_d  = out_data;
      bytes_d     = bytes_done;
      if (out_valid && out_ready) out_valid_d = 1'b0;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data ^ key_q;
         bytes_d     = bytes_done + 16'd1;
      end
      if (start) bytes_d = '0;
   end

   assign busy = (state_q != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         warm_q     <= '0;
         fill_q     <= '0;
         key_q      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         bytes_done <= '0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         fill_q     <= fill_d;
         key_q      <= key_d;
         out_valid  <= out_valid_d;
         out_data   <= out_data_d;
         bytes_done <= bytes_d;
      end
   end

endmodule

// File: tb/tb_trivium_stream_decryptor.sv
// Directed bench for trivium_stream_decryptor; the keystream stub outputs the parity
// of its enable count, so every key byte is 0x55.
module tb_trivium_stream_decryptor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        out_ready = 1'b1;

   logic        ks_load, ks_enable, ks_bit, in_ready, out_valid, busy;
   logic [7:0]  out_data;
   logic [15:0] bytes_done;
   logic [31:0] n;

   logic        z_ks_load, z_ks_enable, z_ks_bit, z_in_ready, z_out_valid, z_busy;
   logic [7:0]  z_out_data;
   logic [15:0] z_bytes_done;
   logic [31:0] z_n;

   int cyc = 0;
   int checks = 0;
   int failures = 0;
   int load_total = 0;
   int en_total = 0;

   always #5 clk = ~clk;

   trivium_stream_decryptor #(.WARMUP(4)) dut (
      .clk(clk), .rst(rst), .start(start),
      .ks_load(ks_load), .ks_enable(ks_enable), .ks_bit(ks_bit),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .bytes_done(bytes_done)
   );

   trivium_stream_decryptor #(.WARMUP(0)) dut_z (
      .clk(clk), .rst(rst), .start(start),
      .ks_load(z_ks_load), .ks_enable(z_ks_enable), .ks_bit(z_ks_bit),
      .in_valid(in_valid), .in_ready(z_in_ready), .in_data(in_data),
      .out_valid(z_out_valid), .out_ready(out_ready), .out_data(z_out_data),
      .busy(z_busy), .bytes_done(z_bytes_done)
   );

   // Keystream stubs: bit after the n-th enable is 1 when n is odd
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n <= 0; ks_bit <= 1'b0;
      end else if (ks_load) begin
         n <= 0; ks_bit <= 1'b0;
      end else if (ks_enable) begin
         n <= n + 1; ks_bit <= ~n[0];
      end
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         z_n <= 0; z_ks_bit <= 1'b0;
      end else if (z_ks_load) begin
         z_n <= 0; z_ks_bit <= 1'b0;
      end else if (z_ks_enable) begin
         z_n <= z_n + 1; z_ks_bit <= ~z_n[0];
      end
   end

   always @(negedge clk) begin
      if (ks_load) load_total <= load_total + 1;
      if (ks_enable) en_total <= en_total + 1;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   task automatic step;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
   endtask

   // Leaves the caller at the falling edge of the cycle where in_ready is high
   task automatic wait_ready(output int c);
      c = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            c = cyc;
            return;
         end
         step();
      end
   endtask

   task automatic test_reset;
      #2;
      checks++; if (ks_load !== 1'b0) begin failures++; $display("FAIL rst_ks_load got=%b exp=0", ks_load); end
      checks++; if (ks_enable !== 1'b0) begin failures++; $display("FAIL rst_ks_enable got=%b exp=0", ks_enable); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
      checks++; if (bytes_done !== 16'd0) begin failures++; $display("FAIL rst_bytes_done got=%0d exp=0", bytes_done); end
      @(posedge clk); #1;
      rst = 1'b0;
      step();
      step();
   endtask

   task automatic test_basic;
      int first = -1;
      int efirst = -1;
      int elast = -1;
      int ecnt = 0;
      int lcyc = -1;
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 40 && first < 0; i++) begin
         @(negedge clk);
         if (ks_load) lcyc = cyc;
         if (ks_enable) begin
            ecnt++;
            if (efirst < 0) efirst = cyc;
            elast = cyc;
         end
         if (in_ready) first = cyc;
         else step();
      end
      checks++; if (lcyc !== 1) begin failures++; $display("FAIL basic_load_cycle got=%0d exp=1", lcyc); end
      checks++; if (efirst !== 2) begin failures++; $display("FAIL basic_en_first got=%0d exp=2", efirst); end
      checks++; if (elast !== 13) begin failures++; $display("FAIL basic_en_last got=%0d exp=13", elast); end
      checks++; if (ecnt !== 12) begin failures++; $display("FAIL basic_en_count got=%0d exp=12", ecnt); end
      checks++; if (first !== 15) begin failures++; $display("FAIL basic_first_ready got=%0d exp=15", first); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_data !== 8'hF0) begin failures++; $display("FAIL basic_out_data got=%h exp=f0", out_data); end
      checks++; if (bytes_done !== 16'd1) begin failures++; $display("FAIL basic_bytes_done got=%0d exp=1", bytes_done); end
      step();
   endtask

   task automatic test_back_to_back;
      logic [7:0] din [3];
      logic [7:0] dexp [3];
      int c;
      din = '{8'h00, 8'hFF, 8'h55};
      dexp = '{8'h55, 8'hAA, 8'h00};
      in_valid = 1'b1; in_data = din[0]; out_ready = 1'b1;
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         wait_ready(c);
         checks++; if (c !== 15 + 10 * k) begin failures++; $display("FAIL b2b_ready_cycle[%0d] got=%0d exp=%0d", k, c, 15 + 10 * k); end
         step();
         if (k < 2) in_data = din[k + 1];
         else in_valid = 1'b0;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_data !== dexp[k]) begin failures++; $display("FAIL b2b_out[%0d] got=%b/%h exp=1/%h", k, out_valid, out_data, dexp[k]); end
         step();
      end
      checks++; if (bytes_done !== 16'd3) begin failures++; $display("FAIL b2b_bytes_done got=%0d exp=3", bytes_done); end
   endtask

   task automatic test_backpressure;
      int c;
      int bad = 0;
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      pulse_start();
      wait_ready(c);
      step();
      out_ready = 1'b0; in_data = 8'h00;
      while (cyc <= 30) begin
         @(negedge clk);
         if (out_valid !== 1'b1 || out_data !== 8'hF0 || in_ready !== 1'b0) bad++;
         step();
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got=%0d_bad_cycles exp=0", bad); end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_release got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin failures++; $display("FAIL bp_second_out got=%b/%h exp=1/55", out_valid, out_data); end
      checks++; if (bytes_done !== 16'd2) begin failures++; $display("FAIL bp_bytes_done got=%0d exp=2", bytes_done); end
      step();
   endtask

   task automatic test_restart;
      int c;
      int base;
      base = load_total;
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      pulse_start();
      while (cyc < 4) step();
      pulse_start();
      @(negedge clk);
      checks++; if (bytes_done !== 16'd0) begin failures++; $display("FAIL restart_bytes_cleared got=%0d exp=0", bytes_done); end
      while (cyc < 8) step();
      pulse_start();
      wait_ready(c);
      checks++; if (load_total - base !== 3) begin failures++; $display("FAIL restart_load_pulses got=%0d exp=3", load_total - base); end
      checks++; if (c !== 15) begin failures++; $display("FAIL restart_first_ready got=%0d exp=15", c); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0) begin failures++; $display("FAIL restart_out got=%b/%h exp=1/f0", out_valid, out_data); end
      checks++; if (bytes_done !== 16'd1) begin failures++; $display("FAIL restart_bytes_done got=%0d exp=1", bytes_done); end
      step();
   endtask

   task automatic test_start_accept;
      int c;
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      pulse_start();
      wait_ready(c);
      start = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sa_ready_with_start got=%b exp=0", in_ready); end
      pulse_start();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL sa_no_output got=%b exp=0", out_valid); end
      checks++; if (bytes_done !== 16'd0) begin failures++; $display("FAIL sa_bytes_done got=%0d exp=0", bytes_done); end
      step();
      wait_ready(c);
      checks++; if (c !== 15) begin failures++; $display("FAIL sa_first_ready got=%0d exp=15", c); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hF0) begin failures++; $display("FAIL sa_out got=%b/%h exp=1/f0", out_valid, out_data); end
      step();
   endtask

   task automatic test_reset_mid;
      int c;
      int base;
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b0;
      pulse_start();
      wait_ready(c);
      step();
      in_valid = 1'b0;
      step();
      step();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || ks_enable !== 1'b1) begin failures++; $display("FAIL rm_precondition got=%b/%b exp=1/1", out_valid, ks_enable); end
      rst = 1'b1;
      #1;
      checks++; if (ks_load !== 1'b0) begin failures++; $display("FAIL rm_ks_load got=%b exp=0", ks_load); end
      checks++; if (ks_enable !== 1'b0) begin failures++; $display("FAIL rm_ks_enable got=%b exp=0", ks_enable); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rm_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rm_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rm_out_data got=%h exp=00", out_data); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%b exp=0", busy); end
      checks++; if (bytes_done !== 16'd0) begin failures++; $display("FAIL rm_bytes_done got=%0d exp=0", bytes_done); end
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      base = en_total;
      for (int i = 0; i < 10; i++) step();
      @(negedge clk);
      checks++; if (en_total - base !== 0) begin failures++; $display("FAIL rm_no_enable got=%0d exp=0", en_total - base); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_idle got=%b exp=0", busy); end
      step();
   endtask

   task automatic test_warmup0;
      int first = -1;
      in_valid = 1'b1; in_data = 8'h00; out_ready = 1'b1;
      pulse_start();
      for (int i = 0; i < 40 && first < 0; i++) begin
         @(negedge clk);
         if (z_in_ready) first = cyc;
         else step();
      end
      checks++; if (first !== 11) begin failures++; $display("FAIL w0_first_ready got=%0d exp=11", first); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (z_out_valid !== 1'b1 || z_out_data !== 8'h55) begin failures++; $display("FAIL w0_key got=%b/%h exp=1/55", z_out_valid, z_out_data); end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_restart();
      test_start_accept();
      test_reset_mid();
      test_warmup0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
